from_serial: RTL and testbench

- Serial-to-parallel deserializer: the receive end of the narrow multi-channel slice stream used between modulation datapath stages.
- Each of NO_CH lanes collects NO_CYC consecutive BW_IN-bit slices, LSB slice first, and reassembles one BW_OUT-bit word per lane.
- Emits the word set with a single-cycle valid pulse.
- Detects truncated frames (a valid gap mid-frame) and flags them.

---
 rtl/from_serial_pkg.sv | 21 ++
 rtl/from_serial_lane.sv | 59 +++++
 rtl/from_serial.sv | 97 +++++++++
 tb/tb_from_serial.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/from_serial_pkg.sv
// ============================================================================
// Module   : from_serial_pkg
// Brief    : Shared sizing helpers for the from_serial deserializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package from_serial_pkg;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Slice counter needs at least one bit even for single-slice frames.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/from_serial_lane.sv
// ============================================================================
// Module   : from_serial_lane
// Brief    : One lane: slice accumulator plus registered output word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module from_serial_lane
  import from_serial_pkg::*;
#(
  parameter int BW_IN  = 2,
  parameter int BW_OUT = 8,
  parameter int NO_CYC = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BW_IN-1:0]  slice_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic              wr_en_i,
  input  logic              ld_en_i,
  output logic [BW_OUT-1:0] word_o
);

  localparam int ACC_W = NO_CYC * BW_IN;

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  merged;
  logic [BW_OUT-1:0] word_q;
  logic [BW_OUT-1:0] word_d;

  // The final slice is merged combinationally so the word loads on the same edge.
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < NO_CYC; k++) begin
      if (idx_i == CNT_W'(k)) begin
        merged[k*BW_IN +: BW_IN] = slice_i;
      end
    end
    acc_d  = wr_en_i ? merged : acc_q;
    word_d = ld_en_i ? merged[BW_OUT-1:0] : word_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      word_q <= '0;
    end else begin
      acc_q  <= acc_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

`default_nettype wire

// File: rtl/from_serial.sv
// ============================================================================
// Module   : from_serial
// Brief    : Multi-lane serial-to-parallel deserializer with truncation flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module from_serial
  import from_serial_pkg::*;
#(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 2,
  parameter int BW_OUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vld_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]   data_in,
  output logic                          vld_out,
  output logic [NO_CH-1:0][BW_OUT-1:0]  data_out,
  output logic                          err_out
);

  localparam int NO_CYC = ceil_div(BW_OUT, BW_IN);
  localparam int CNT_W  = cnt_width(NO_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NO_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             vld_q;
  logic             vld_d;
  logic             err_q;
  logic             err_d;
  logic             wr_en;
  logic             ld_en;
  logic             last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);

  // A valid gap while collecting discards the partial frame and flags it.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    if (vld_in) begin
      if (last) begin
        cnt_d = '0;
        vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = '0;
      err_d = 1'b1;
    end
  end

  always_comb begin
    wr_en = vld_in;
    ld_en = vld_in && last;
  end

  for (genvar g = 0; g < NO_CH; g++) begin : g_lane
    from_serial_lane #(
      .BW_IN  (BW_IN),
      .BW_OUT (BW_OUT),
      .NO_CYC (NO_CYC),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .slice_i (data_in[g]),
      .idx_i   (cnt_q),
      .wr_en_i (wr_en),
      .ld_en_i (ld_en),
      .word_o  (data_out[g])
    );
  end

  assign vld_out = vld_q;
  assign err_out = err_q;

endmodule

`default_nettype wire

// File: tb/tb_from_serial.sv
// ============================================================================
// Module   : tb_from_serial
// Brief    : Directed, table-driven bench for from_serial.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_from_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: two lanes, 2-bit slices, 8-bit words.
  logic            rst;
  logic            vld_in;
  logic [1:0][1:0] data_in;
  logic            vld_out;
  logic [1:0][7:0] data_out;
  logic            err_out;

  from_serial #(.NO_CH(2), .BW_IN(2), .BW_OUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .vld_out  (vld_out),
    .data_out (data_out),
    .err_out  (err_out)
  );

  // Non-multiple width: 3-bit slices, 8-bit word, three slices per frame.
  logic            rst3;
  logic            vld3_in;
  logic [0:0][2:0] data3_in;
  logic            vld3_out;
  logic [0:0][7:0] data3_out;
  logic            err3_out;

  from_serial #(.NO_CH(1), .BW_IN(3), .BW_OUT(8)) dut3 (
    .clk      (clk),
    .rst      (rst3),
    .vld_in   (vld3_in),
    .data_in  (data3_in),
    .vld_out  (vld3_out),
    .data_out (data3_out),
    .err_out  (err3_out)
  );

  // Single-slice frames.
  logic            rst1;
  logic            vld1_in;
  logic [0:0][7:0] data1_in;
  logic            vld1_out;
  logic [0:0][7:0] data1_out;
  logic            err1_out;

  from_serial #(.NO_CH(1), .BW_IN(8), .BW_OUT(8)) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .vld_in   (vld1_in),
    .data_in  (data1_in),
    .vld_out  (vld1_out),
    .data_out (data1_out),
    .err_out  (err1_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [1:0] d0;
    logic [1:0] d1;
    logic       ev;
    logic       ee;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vec [NVEC];

  initial begin
    // Each record: inputs before an edge, outputs expected just after it.
    vec[0]  = '{1, 0, 2'd0, 2'd0, 0, 0, 8'h00, 8'h00};
    vec[1]  = '{0, 1, 2'd0, 2'd3, 0, 0, 8'h00, 8'h00};
    vec[2]  = '{0, 1, 2'd1, 2'd3, 0, 0, 8'h00, 8'h00};
    vec[3]  = '{0, 1, 2'd2, 2'd3, 0, 0, 8'h00, 8'h00};
    vec[4]  = '{0, 1, 2'd3, 2'd3, 1, 0, 8'hE4, 8'hFF};
    vec[5]  = '{0, 0, 2'd1, 2'd1, 0, 0, 8'hE4, 8'hFF};
    vec[6]  = '{0, 1, 2'd1, 2'd2, 0, 0, 8'hE4, 8'hFF};
    vec[7]  = '{0, 1, 2'd1, 2'd2, 0, 0, 8'hE4, 8'hFF};
    vec[8]  = '{0, 0, 2'd3, 2'd3, 0, 1, 8'hE4, 8'hFF};
    vec[9]  = '{0, 0, 2'd0, 2'd0, 0, 0, 8'hE4, 8'hFF};
    vec[10] = '{0, 1, 2'd3, 2'd1, 0, 0, 8'hE4, 8'hFF};
    vec[11] = '{0, 1, 2'd3, 2'd0, 0, 0, 8'hE4, 8'hFF};
    vec[12] = '{0, 1, 2'd3, 2'd0, 0, 0, 8'hE4, 8'hFF};
    vec[13] = '{0, 1, 2'd3, 2'd2, 1, 0, 8'hFF, 8'h81};
    vec[14] = '{0, 0, 2'd0, 2'd0, 0, 0, 8'hFF, 8'h81};
    vec[15] = '{0, 1, 2'd1, 2'd1, 0, 0, 8'hFF, 8'h81};
    vec[16] = '{0, 1, 2'd1, 2'd1, 0, 0, 8'hFF, 8'h81};
    vec[17] = '{0, 1, 2'd1, 2'd1, 0, 0, 8'hFF, 8'h81};
    vec[18] = '{1, 1, 2'd3, 2'd3, 0, 0, 8'h00, 8'h00};
    vec[19] = '{0, 1, 2'd0, 2'd3, 0, 0, 8'h00, 8'h00};
    vec[20] = '{0, 1, 2'd1, 2'd2, 0, 0, 8'h00, 8'h00};
    vec[21] = '{0, 1, 2'd2, 2'd1, 0, 0, 8'h00, 8'h00};
    vec[22] = '{0, 1, 2'd3, 2'd0, 1, 0, 8'hE4, 8'h1B};
    vec[23] = '{0, 0, 2'd0, 2'd0, 0, 0, 8'hE4, 8'h1B};
  end

  initial begin
    logic [7:0] w0 [2];
    logic [7:0] w1 [2];
    logic [1:0] sl0 [4];
    logic [1:0] sl1 [4];
    logic [7:0] m0;
    logic [7:0] m1;
    int pulses;
    int errs_seen;

    rst = 1'b1; vld_in = 1'b0; data_in = '0;
    rst3 = 1'b1; vld3_in = 1'b0; data3_in = '0;
    rst1 = 1'b1; vld1_in = 1'b0; data1_in = '0;
    #2;

    for (int i = 0; i < NVEC; i++) begin
      rst = vec[i].r; vld_in = vec[i].v;
      data_in[0] = vec[i].d0; data_in[1] = vec[i].d1;
      tick();
      check($sformatf("vec%0d vld_out", i), 32'(vld_out), 32'(vec[i].ev));
      check($sformatf("vec%0d err_out", i), 32'(err_out), 32'(vec[i].ee));
      check($sformatf("vec%0d data_out0", i), 32'(data_out[0]), 32'(vec[i].e0));
      check($sformatf("vec%0d data_out1", i), 32'(data_out[1]), 32'(vec[i].e1));
    end

    // Loopback: serialize words LSB slice first, two frames back-to-back.
    w0[0] = 8'hA5; w1[0] = 8'h3C;
    w0[1] = 8'h5A; w1[1] = 8'hC3;
    for (int c = 0; c < 8; c++) begin
      vld_in = 1'b1;
      data_in[0] = w0[c/4][(c%4)*2 +: 2];
      data_in[1] = w1[c/4][(c%4)*2 +: 2];
      tick();
      check($sformatf("loop c%0d err_out", c), 32'(err_out), 32'd0);
      if (c % 4 == 3) begin
        check($sformatf("loop c%0d vld_out", c), 32'(vld_out), 32'd1);
        check($sformatf("loop c%0d lane0", c), 32'(data_out[0]), 32'(w0[c/4]));
        check($sformatf("loop c%0d lane1", c), 32'(data_out[1]), 32'(w1[c/4]));
      end else begin
        check($sformatf("loop c%0d vld_out", c), 32'(vld_out), 32'd0);
      end
    end
    vld_in = 1'b0;
    tick();
    check("loop tail vld_out", 32'(vld_out), 32'd0);
    check("loop tail err_out", 32'(err_out), 32'd0);

    // Continuous stream of 40 slices against an independent packing model.
    pulses = 0;
    errs_seen = 0;
    for (int i = 0; i < 40; i++) begin
      vld_in = 1'b1;
      data_in[0] = 2'(i);
      data_in[1] = 2'(i * 3 + 1);
      sl0[i % 4] = 2'(i);
      sl1[i % 4] = 2'(i * 3 + 1);
      tick();
      if (err_out) errs_seen++;
      if (vld_out) pulses++;
      if (i % 4 == 3) begin
        m0 = {sl0[3], sl0[2], sl0[1], sl0[0]};
        m1 = {sl1[3], sl1[2], sl1[1], sl1[0]};
        check($sformatf("stream %0d vld_out", i), 32'(vld_out), 32'd1);
        check($sformatf("stream %0d lane0", i), 32'(data_out[0]), 32'(m0));
        check($sformatf("stream %0d lane1", i), 32'(data_out[1]), 32'(m1));
      end
    end
    vld_in = 1'b0;
    tick();
    check("stream pulse count", 32'(pulses), 32'd10);
    check("stream err count", 32'(errs_seen), 32'd0);

    // Non-multiple width instance.
    rst3 = 1'b0;
    tick();
    check("w3 reset vld_out", 32'(vld3_out), 32'd0);
    check("w3 reset data_out", 32'(data3_out[0]), 32'd0);
    vld3_in = 1'b1; data3_in[0] = 3'b101; tick();
    check("w3 s0 vld_out", 32'(vld3_out), 32'd0);
    data3_in[0] = 3'b010; tick();
    check("w3 s1 vld_out", 32'(vld3_out), 32'd0);
    data3_in[0] = 3'b111; tick();
    check("w3 vld_out", 32'(vld3_out), 32'd1);
    check("w3 data_out", 32'(data3_out[0]), 32'hD5);
    check("w3 err_out", 32'(err3_out), 32'd0);
    vld3_in = 1'b0; tick();
    check("w3 tail vld_out", 32'(vld3_out), 32'd0);

    // Single-slice frames: each valid cycle completes a word, gaps never error.
    rst1 = 1'b0;
    tick();
    vld1_in = 1'b1; data1_in[0] = 8'h3E; tick();
    check("n1 a vld_out", 32'(vld1_out), 32'd1);
    check("n1 a data_out", 32'(data1_out[0]), 32'h3E);
    data1_in[0] = 8'hC7; tick();
    check("n1 b vld_out", 32'(vld1_out), 32'd1);
    check("n1 b data_out", 32'(data1_out[0]), 32'hC7);
    vld1_in = 1'b0; data1_in[0] = 8'h00; tick();
    check("n1 gap vld_out", 32'(vld1_out), 32'd0);
    check("n1 gap err_out", 32'(err1_out), 32'd0);
    check("n1 gap data_out", 32'(data1_out[0]), 32'hC7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
